// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared widths and word/address types for the MCPU.
// Imported by the RAM controller, its array and the CPU stages.
package mcpu_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int ADDR_WIDTH = 8;

    typedef logic [WORD_SIZE-1:0]  word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/mcpu_ram_array.sv
// mcpu_ram_array: unreset word array with one write port
// and two asynchronous read taps.
module mcpu_ram_array
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [WORD_SIZE-1:0]  rd_data_a,
    output logic [WORD_SIZE-1:0]  rd_data_b
);

    localparam int RAM_SIZE = 1 << ADDR_WIDTH;

    logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

    // Reset blocks writes but never clears the contents.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mcpu_ram_controller.sv
// mcpu_ram_controller: registered data and fetch read ports over
// a shared array, with write-first bypass on both ports.
module mcpu_ram_controller
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [WORD_SIZE-1:0]  datawr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WORD_SIZE-1:0]  datard,
    input  logic [ADDR_WIDTH-1:0] instraddr,
    output logic [WORD_SIZE-1:0]  instrrd
);

    localparam int RAM_SIZE = 1 << ADDR_WIDTH;

    logic [WORD_SIZE-1:0] tap_data;
    logic [WORD_SIZE-1:0] tap_instr;
    logic [WORD_SIZE-1:0] data_nxt;
    logic [WORD_SIZE-1:0] instr_nxt;

    mcpu_ram_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) raminst (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wr_addr  (addr),
        .wr_data  (datawr),
        .rd_addr_a(addr),
        .rd_addr_b(instraddr),
        .rd_data_a(tap_data),
        .rd_data_b(tap_instr)
    );

    // Data port shares addr with the write, so any write wins.
    always_comb begin
        data_nxt  = tap_data;
        instr_nxt = tap_instr;
        if (we) begin
            data_nxt = datawr;
        end
        if (we && (instraddr == addr)) begin
            instr_nxt = datawr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            datard  <= '0;
            instrrd <= '0;
        end else begin
            if (re) begin
                datard <= data_nxt;
            end
            instrrd <= instr_nxt;
        end
    end

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// tb_mcpu_ram_controller: fill/sweep, table vectors and random
// traffic against an array-based model of the RAM.
module tb_mcpu_ram_controller;
    import mcpu_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  we;
    word_t datawr;
    logic  re;
    addr_t addr;
    word_t datard;
    addr_t instraddr;
    word_t instrrd;

    int vectors;
    int miscompares;

    word_t mm [0:255];
    word_t md;
    word_t mi;

    typedef struct {
        logic  rst_n;
        logic  we;
        logic  re;
        addr_t addr;
        word_t datawr;
        addr_t ia;
        word_t exp_d;
        word_t exp_i;
        logic  chk_mem;
        word_t exp_mem;
    } vec_t;

    vec_t tbl [12];

    mcpu_ram_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .datawr   (datawr),
        .re       (re),
        .addr     (addr),
        .datard   (datard),
        .instraddr(instraddr),
        .instrrd  (instrrd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act,
                         input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Model: the write lands first, then both ports read the array.
    task automatic step(input logic r, input logic w, input logic e,
                        input addr_t a, input word_t dw,
                        input addr_t ia);
        rst_n     = r;
        we        = w;
        re        = e;
        addr      = a;
        datawr    = dw;
        instraddr = ia;
        @(posedge clk);
        if (!r) begin
            md = '0;
            mi = '0;
        end else begin
            if (w) mm[a] = dw;
            if (e) md = mm[a];
            mi = mm[ia];
        end
        #1;
    endtask

    initial begin
        word_t v;
        addr_t a;
        addr_t ia;
        logic  w;
        logic  e;
        logic  r;

        vectors     = 0;
        miscompares = 0;
        md = '0;
        mi = '0;
        for (int i = 0; i < 256; i++) mm[i] = '0;

        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("reset_datard", datard, 8'd0);
        check("reset_instrrd", instrrd, 8'd0);

        for (int i = 0; i < 256; i++) begin
            v = (i % 2 == 0) ? 8'd26 : 8'd41;
            step(1'b1, 1'b1, 1'b0, addr_t'(i), v, addr_t'(i));
            check("fill_mem", dut.raminst.mem[i], v);
            check("fill_bypass_instr", instrrd, v);
            check("fill_datard_hold", datard, 8'd0);
        end

        for (int k = 0; k <= 256; k++) begin
            a = addr_t'(k);
            v = (a[0] == 1'b0) ? 8'd26 : 8'd41;
            step(1'b1, 1'b0, 1'b1, a, 8'd0, a);
            check("sweep_datard", datard, v);
            check("sweep_instrrd", instrrd, v);
        end

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd3,  8'h00, 8'd3,
                    8'd41,  8'd41, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd4,  8'h00, 8'd4,
                    8'd41,  8'd26, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd4,  8'h00, 8'd7,
                    8'd41,  8'd41, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'd10, 8'h5A, 8'd10,
                    8'h5A,  8'h5A, 1'b1, 8'h5A};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'd2,  8'h00, 8'd5,
                    8'd26,  8'd41, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd3,  8'h00, 8'd3,
                    8'd41,  8'd41, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'd7,  8'hFF, 8'd7,
                    8'd0,   8'd0,  1'b1, 8'd41};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd7,  8'h00, 8'd7,
                    8'd0,   8'd41, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'd7,  8'h00, 8'd10,
                    8'd41,  8'h5A, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd20, 8'h33, 8'd20,
                    8'd41,  8'h33, 1'b1, 8'h33};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'd20, 8'h00, 8'd255,
                    8'h33,  8'd41, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 8'd255, 8'hC3, 8'd0,
                    8'hC3,  8'd26, 1'b1, 8'hC3};

        for (int t = 0; t < 12; t++) begin
            step(tbl[t].rst_n, tbl[t].we, tbl[t].re, tbl[t].addr,
                 tbl[t].datawr, tbl[t].ia);
            check($sformatf("tbl%0d_datard", t), datard, tbl[t].exp_d);
            check($sformatf("tbl%0d_instrrd", t), instrrd,
                  tbl[t].exp_i);
            if (tbl[t].chk_mem) begin
                check($sformatf("tbl%0d_mem", t),
                      dut.raminst.mem[tbl[t].addr], tbl[t].exp_mem);
            end
        end

        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 31) != 0);
            w  = $urandom_range(0, 1) == 1;
            e  = $urandom_range(0, 1) == 1;
            a  = addr_t'($urandom_range(0, 255));
            ia = ($urandom_range(0, 3) == 0) ? a
                                            : addr_t'($urandom_range(0, 255));
            v  = word_t'($urandom_range(0, 255));
            step(r, w, e, a, v, ia);
            check("rand_datard", datard, md);
            check("rand_instrrd", instrrd, mi);
            check("rand_mem", dut.raminst.mem[a], mm[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
